// File: rtl/gbuff_checker_pkg.sv
// Shared definitions for the global-buffer result checker: default geometry
// and the checker FSM encoding.
package gbuff_checker_pkg;

  localparam int DEF_LANE_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DIM_W  = 4;
  localparam int DEF_ERR_W  = 16;

  localparam int WORD_SIZE       = DEF_LANES * DEF_LANE_W;
  localparam int GBUFF_ADDR_SIZE = DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_e;

endpackage

// File: rtl/gbuff_lane_cmp.sv
// Combinational per-word compare: lane-wise mismatch (optionally against the
// lane-reversed golden word), mismatch count and lowest mismatching lane.
module gbuff_lane_cmp #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic [LANES*LANE_W-1:0] out_word,
  input  logic [LANES*LANE_W-1:0] gold_word,
  input  logic [LANES-1:0]        lane_mask,
  input  logic                    mode,
  output logic [LANES-1:0]        mism,
  output logic [CW-1:0]           mism_cnt,
  output logic [LW-1:0]           first_lane
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [LANE_W-1:0] o_lane, g_lane_val;
    assign o_lane     = out_word[k*LANE_W +: LANE_W];
    assign g_lane_val = mode ? gold_word[(LANES-1-k)*LANE_W +: LANE_W]
                             : gold_word[k*LANE_W +: LANE_W];
    assign mism[k]    = lane_mask[k] & (o_lane != g_lane_val);
  end

  // Walk high to low so the last hit left standing is the lowest lane.
  always_comb begin
    mism_cnt   = '0;
    first_lane = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      mism_cnt = mism_cnt + CW'(mism[k]);
      if (mism[k]) first_lane = LW'(k);
    end
  end

endmodule

// File: rtl/gbuff_checker.sv
// Streams an m x n result out of the output and golden buffers in lockstep,
// compares them lane by lane and reports error count, pass and first error.
module gbuff_checker
  import gbuff_checker_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W,
  parameter int LANES  = DEF_LANES,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W,
  parameter int ERR_W  = DEF_ERR_W,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIM_W-1:0]        m,
  input  logic [DIM_W-1:0]        n,
  input  logic                    mode,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [LANES*LANE_W-1:0] out_rdata,
  input  logic [LANES*LANE_W-1:0] gold_rdata,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_cnt,
  output logic                    first_err_valid,
  output logic [ADDR_W-1:0]       first_err_addr,
  output logic [LW-1:0]           first_err_lane
);

  chk_state_e       state;
  logic [1:0]       vld_pipe;   // [0] address issued, [1] data returned
  logic [DIM_W-1:0] m_q, rpw_q, rem_q, row, col;
  logic             mode_q;
  logic [LANES-1:0] issue_mask, mask_d;
  logic [ADDR_W-1:0] addr_d;
  logic             last_d, last_col, is_last;

  logic [LANES-1:0] mism;
  logic [CW-1:0]    mism_cnt;
  logic [LW-1:0]    mism_lane;
  logic [ERR_W:0]   err_sum;
  logic [ERR_W-1:0] err_next;

  assign rd_en    = vld_pipe[0];
  assign last_col = (col == rpw_q - 1'b1);
  assign is_last  = last_col && (row == m_q - 1'b1);

  // Only the trailing word of a row can be partial; its upper lanes are padding.
  always_comb begin
    issue_mask = '1;
    if (last_col && rem_q != '0)
      for (int k = 0; k < LANES; k++) issue_mask[k] = (k < int'(rem_q));
  end

  gbuff_lane_cmp #(.LANE_W(LANE_W), .LANES(LANES)) u_cmp (
    .out_word  (out_rdata),
    .gold_word (gold_rdata),
    .lane_mask (mask_d),
    .mode      (mode_q),
    .mism      (mism),
    .mism_cnt  (mism_cnt),
    .first_lane(mism_lane)
  );

  assign err_sum  = {1'b0, err_cnt} + (ERR_W+1)'(mism_cnt);
  assign err_next = !vld_pipe[1] ? err_cnt
                  : (err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      vld_pipe        <= '0;
      rd_addr         <= '0;
      m_q             <= '0;
      rpw_q           <= '0;
      rem_q           <= '0;
      row             <= '0;
      col             <= '0;
      mode_q          <= 1'b0;
      mask_d          <= '0;
      addr_d          <= '0;
      last_d          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_cnt         <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      first_err_lane  <= '0;
    end else begin
      done        <= 1'b0;
      vld_pipe[1] <= vld_pipe[0];
      mask_d      <= issue_mask;
      addr_d      <= rd_addr;
      last_d      <= vld_pipe[0] & is_last;
      err_cnt     <= err_next;
      if (vld_pipe[1] && |mism && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= addr_d;
        first_err_lane  <= mism_lane;
      end

      unique case (state)
        ST_IDLE: if (start) begin
          m_q             <= m;
          rpw_q           <= DIM_W'((int'(n) + LANES - 1) / LANES);
          rem_q           <= DIM_W'(int'(n) % LANES);
          mode_q          <= mode;
          row             <= '0;
          col             <= '0;
          rd_addr         <= '0;
          busy            <= 1'b1;
          err_cnt         <= '0;
          first_err_valid <= 1'b0;
          first_err_addr  <= '0;
          first_err_lane  <= '0;
          if (m != '0 && n != '0) begin
            state       <= ST_RUN;
            vld_pipe[0] <= 1'b1;
            pass        <= 1'b0;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
            pass  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (is_last) begin
            vld_pipe[0] <= 1'b0;
            state       <= ST_DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
            if (last_col) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_DRAIN: if (last_d) begin
          state <= ST_DONE;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gbuff_checker.sv
// Randomized scoreboard bench for gbuff_checker: element-level reference model,
// two instances (default and 4-bit error counter) run in lockstep.
module tb_gbuff_checker;
  localparam int LANE_W = 8, LANES = 4, ADDR_W = 8, DIM_W = 4, WORD_W = LANES * LANE_W;

  typedef struct {
    int err;
    int w;
    int fv;
    int fa;
    int fl;
    int c_acc;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [DIM_W-1:0]  m = '0, n = '0;
  logic [WORD_W-1:0] out_rdata = '0, gold_rdata = '0;
  logic [WORD_W-1:0] out_mem[256], gold_mem[256];

  logic rd_en, busy, done, pass, fev;
  logic [ADDR_W-1:0] rd_addr, fea;
  logic [1:0] fel;
  logic [15:0] err_cnt;
  logic rd_en1, busy1, done1, pass1, fev1;
  logic [ADDR_W-1:0] rd_addr1, fea1;
  logic [1:0] fel1;
  logic [3:0] err_cnt1;

  int cyc = 0, n_cmp = 0, n_fail = 0, done_seen = 0, rd_cnt = 0, addr_ok = 1;
  exp_t exp_q[$];

  gbuff_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .n(n), .mode(mode),
    .rd_en(rd_en), .rd_addr(rd_addr), .out_rdata(out_rdata), .gold_rdata(gold_rdata),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_valid(fev), .first_err_addr(fea), .first_err_lane(fel));

  gbuff_checker #(.ERR_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .m(m), .n(n), .mode(mode),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .out_rdata(out_rdata), .gold_rdata(gold_rdata),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .first_err_valid(fev1), .first_err_addr(fea1), .first_err_lane(fel1));

  always #5 clk = ~clk;

  // Both buffers: registered read, data one cycle after rd_en.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) begin
      out_rdata  <= out_mem[rd_addr];
      gold_rdata <= gold_mem[rd_addr];
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [LANE_W-1:0] lane(input logic [WORD_W-1:0] w, input int k);
    return w[k*LANE_W +: LANE_W];
  endfunction

  // kind: 0 clean, 1 sparse random errors, 2 every valid element wrong.
  task automatic fill(input int mm, input int nn, input int md, input int kind);
    int rw;
    rw = (nn + LANES - 1) / LANES;
    for (int a = 0; a < 256; a++) begin
      gold_mem[a] = $urandom;
      out_mem[a]  = $urandom;
    end
    for (int r = 0; r < mm; r++)
      for (int j = 0; j < nn; j++) begin
        int a, k, gk;
        logic [LANE_W-1:0] v;
        a = r * rw + j / LANES;
        k = j % LANES;
        gk = md ? LANES - 1 - k : k;
        v = lane(gold_mem[a], gk);
        if (kind == 2 || (kind == 1 && $urandom_range(0, 7) == 0)) v = ~v;
        out_mem[a][k*LANE_W +: LANE_W] = v;
      end
  endtask

  // Element view of the result: element (r,j) sits in word r*R + j/LANES.
  function automatic exp_t model(input int mm, input int nn, input int md);
    exp_t e;
    int rw;
    rw = (nn + LANES - 1) / LANES;
    e.w = mm * rw; e.err = 0; e.fv = 0; e.fa = 0; e.fl = 0; e.c_acc = 0;
    for (int r = 0; r < mm; r++)
      for (int j = 0; j < nn; j++) begin
        int a, k, gk;
        a = r * rw + j / LANES;
        k = j % LANES;
        gk = md ? LANES - 1 - k : k;
        if (lane(out_mem[a], k) != lane(gold_mem[a], gk)) begin
          if (e.fv == 0) begin e.fv = 1; e.fa = a; e.fl = k; end
          e.err++;
        end
      end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      rd_cnt = 0;
      addr_ok = 1;
    end else begin
      if (rd_en) begin
        if (rd_addr != ADDR_W'(rd_cnt)) addr_ok = 0;
        rd_cnt++;
      end
      if (rd_en1 !== rd_en || rd_addr1 !== rd_addr) addr_ok = 0;
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", done, 0);
        else begin
          e = exp_q.pop_front();
          chk("latency", cyc - e.c_acc + 1, e.w == 0 ? 1 : e.w + 2);
          chk("rd_count", rd_cnt, e.w);
          chk("addr_seq", addr_ok, 1);
          chk("err_cnt", err_cnt, e.err);
          chk("pass", pass, e.err == 0);
          chk("first_valid", fev, e.fv);
          chk("first_addr", fea, e.fa);
          chk("first_lane", fel, e.fl);
          chk("sat_err_cnt", err_cnt1, e.err > 15 ? 15 : e.err);
          chk("sat_pass", pass1, e.err == 0);
          chk("sat_first_addr", fea1, e.fa);
          chk("sat_done", done1, 1);
        end
        rd_cnt = 0;
        addr_ok = 1;
        done_seen++;
      end
    end
  end

  task automatic wait_done(input int ds0, input int cnt);
    for (int i = 0; i < 300 && done_seen - ds0 < cnt; i++) @(negedge clk);
    chk("done_count", done_seen - ds0, cnt);
  endtask

  task automatic run(input int mm, input int nn, input int md, input bit poke);
    exp_t e;
    int ds0;
    e = model(mm, nn, md);
    @(negedge clk);
    m = DIM_W'(mm); n = DIM_W'(nn); mode = md[0]; start = 1'b1;
    e.c_acc = cyc + 1;
    exp_q.push_back(e);
    ds0 = done_seen;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (poke && e.w > 0) begin
      m = ~m; n = ~n; mode = ~mode; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(ds0, 1);
    repeat (2) @(negedge clk);
    chk("hold_err_cnt", err_cnt, e.err);
    chk("hold_pass", pass, e.err == 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_fev"}, fev, 0);
    chk({tag, "_fea"}, fea, 0);
    chk({tag, "_fel"}, fel, 0);
    chk({tag, "_sat_err_cnt"}, err_cnt1, 0);
  endtask

  initial begin
    exp_t e;
    int ds0;
    #2;
    chk_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    fill(4, 12, 1, 0); run(4, 12, 1, 0);           // reversed, all equal
    fill(4, 12, 1, 0);
    out_mem[5][2*LANE_W +: LANE_W] = out_mem[5][2*LANE_W +: LANE_W] ^ 8'h5a;
    run(4, 12, 1, 1);                              // single corrupted lane, start poked
    fill(3, 6, 0, 0); run(3, 6, 0, 0);             // padding lanes hold garbage
    fill(4, 12, 0, 2); run(4, 12, 0, 0);           // every lane wrong, narrow counter saturates
    run(0, 5, 0, 0);                               // empty result

    // Reset in the middle of a 12-word run.
    fill(4, 12, 0, 2);
    @(negedge clk);
    m = 4'd4; n = 4'd12; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("midrun");
    repeat (3) @(negedge clk);
    chk("reset_no_done", done, 0);
    rst_n = 1'b1;
    fill(4, 12, 1, 1); run(4, 12, 1, 0);

    // Start held high through DONE restarts only after IDLE.
    fill(2, 5, 1, 1);
    e = model(2, 5, 1);
    @(negedge clk);
    m = 4'd2; n = 4'd5; mode = 1'b1; start = 1'b1;
    e.c_acc = cyc + 1;
    exp_q.push_back(e);
    e.c_acc = e.c_acc + e.w + 3;
    exp_q.push_back(e);
    ds0 = done_seen;
    repeat (e.w + 4) @(negedge clk);
    start = 1'b0;
    wait_done(ds0, 2);
    repeat (2) @(negedge clk);

    for (int t = 0; t < 25; t++) begin
      int mm, nn, md, kind;
      mm = $urandom_range(0, 15);
      nn = $urandom_range(0, 15);
      md = $urandom_range(0, 1);
      kind = $urandom_range(0, 2);
      fill(mm, nn, md, kind);
      run(mm, nn, md, $urandom_range(0, 1) == 1);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/gbuff_checker.md
GBUFF_CHECKER -- requirements
Module: gbuff_checker

Interface
REQ-001 SHALL have parameter LANE_W, default 8, bits per result element (byte lane).
REQ-002 SHALL have parameter LANES, default 4, lanes per buffer word; word width is LANES*LANE_W.
REQ-003 SHALL have parameter ADDR_W, default 8, address width of both buffers.
REQ-004 SHALL have parameter DIM_W, default 4, width of the m and n dimension inputs.
REQ-005 SHALL have parameter ERR_W, default 16, error-counter width.
REQ-006 SHALL have ports:
  - clk  in  1  sole clock, rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - start  in  1  begin check; sampled only in IDLE.
  - m  in  DIM_W  result rows.
  - n  in  DIM_W  result columns.
  - mode  in  1  0 = same lane order; 1 = reversed lane order.
  - rd_en  out  1  read strobe for both buffers.
  - rd_addr  out  ADDR_W  shared address for output and golden buffers.
  - out_rdata  in  LANES*LANE_W  output-buffer word, valid one cycle after rd_en.
  - gold_rdata  in  LANES*LANE_W  golden word, valid one cycle after rd_en.
  - busy  out  1  high from start acceptance until done.
  - done  out  1  one-cycle completion pulse.
  - pass  out  1  high when err_cnt==0 at done; held until next start.
  - err_cnt  out  ERR_W  saturating count of mismatching valid lanes.
  - first_err_valid  out  1  a mismatch has been recorded.
  - first_err_addr  out  ADDR_W  word address of first mismatch.
  - first_err_lane  out  log2(LANES)  lowest mismatching output lane in that word.

Function
REQ-007 SHALL compute words-per-row R = ceil(n/LANES) and total words W = m*R, with W < 2^ADDR_W.
REQ-008 SHALL use FSM states IDLE, RUN, DRAIN, DONE: IDLE->RUN on start with m,n nonzero; IDLE->DONE on start with m or n zero; RUN->DRAIN after issuing address W-1; DRAIN->DONE after the last compare; DONE->IDLE unconditionally.
REQ-009 SHALL in RUN assert rd_en for exactly W consecutive cycles with rd_addr 0..W-1 in ascending order, one address per cycle.
REQ-010 SHALL register the compare of each word in the cycle after its data returns; done SHALL pulse exactly W+2 cycles after the start edge (1 cycle when W=0).
REQ-011 SHALL compare output lane k against golden lane k when mode=0, and against golden lane LANES-1-k when mode=1.
REQ-012 SHALL ignore lanes k >= (n mod LANES) in the last word of each row when n mod LANES != 0; all lanes of other words are valid.
REQ-013 SHALL add the number of mismatching valid lanes per word to err_cnt, saturating at 2^ERR_W-1.
REQ-014 SHALL latch first_err_* on the first mismatching word only; later mismatches SHALL NOT overwrite them.
REQ-015 SHALL sample m, n and mode at start acceptance and ignore changes on them until IDLE.
REQ-016 SHALL ignore start while busy; start held high through DONE SHALL start a new check only after IDLE is re-entered.
REQ-017 SHALL clear err_cnt, pass and first_err_* on start acceptance; results SHALL hold from done until the next start.

Reset
REQ-018 SHALL on rst_n low immediately force IDLE, with rd_en, busy, done, pass, first_err_valid = 0 and err_cnt, rd_addr, first_err_addr, first_err_lane = 0.
REQ-019 SHALL, on reset during RUN or DRAIN, abandon the check with no done pulse; the next start SHALL run cleanly.

Structure
REQ-020 SHALL place the FSM state encoding and the default parameter values in the shared TPU package/define file next to WORD_SIZE and GBUFF_ADDR_SIZE.
REQ-021 SHALL instantiate a sub-module gbuff_lane_cmp (combinational): word pair, lane mask and mode in; mismatch vector, popcount and lowest-mismatch lane out.

Verification
REQ-022 SHALL cover: defaults, m=4, n=12, mode=1, all lanes equal (reversed) -> W=12, done at cycle 14, err_cnt=0, pass=1.
REQ-023 SHALL cover: same setup, output word 5 lane 2 corrupted -> err_cnt=1, first_err_addr=5, first_err_lane=2, pass=0.
REQ-024 SHALL cover: m=3, n=6, mode=0, garbage in lanes 2-3 of words 1, 3, 5 -> err_cnt=0, pass=1, done at cycle 8.
REQ-025 SHALL cover: ERR_W=4, m=4, n=12, every lane wrong -> err_cnt=15 (saturated), first_err_addr=0, first_err_lane=0.
REQ-026 SHALL cover: m=0, n=5 -> no rd_en, done one cycle after start, pass=1; start pulsed while busy -> ignored.
REQ-027 SHALL cover: rst_n low in cycle 5 of a 12-word run -> all outputs at reset values and no done pulse; the next start gives correct results.
